// File: rtl/exp_logic_pipe.sv
// Pipelined FMA/ADD exponent logic: product exponent, signed exponent difference,
// max exponent and clamped alignment shift, with a valid/ready handshake, a
// two-stage register pipeline, special-exponent flags and an opaque tag.
module exp_logic_pipe #(
  parameter int sig_width = 23,
  parameter int ex_width  = 8,
  parameter int MAX_SHIFT = 3*sig_width+5,
  parameter int TAG_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                mode,
  input  logic [ex_width-1:0] Ea,
  input  logic [ex_width-1:0] Eb,
  input  logic [ex_width-1:0] Ec,
  input  logic [TAG_W-1:0]    tag_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ex_width+1:0] shift,
  output logic [ex_width+1:0] sd,
  output logic [ex_width+1:0] max_exp,
  output logic                prod_undf,
  output logic                shift_sat,
  output logic                spec_inf,
  output logic                spec_zero,
  output logic [TAG_W-1:0]    tag_out
);

  localparam int W = ex_width + 2;
  localparam logic [W-1:0] BIAS        = W'((1 << (ex_width-1)) - 1);
  localparam logic [W-1:0] SHIFT_OFF   = W'(sig_width + 4);
  localparam logic [W-1:0] MAX_SHIFT_W = W'(MAX_SHIFT);
  localparam logic [ex_width-1:0] EXP_ONES = '1;
  localparam logic [ex_width-1:0] EXP_ZERO = '0;

  // Brent-Kung parallel-prefix adder (carry-in 0): up-sweep builds group
  // generate/propagate at power-of-two spans, down-sweep fills the gaps.
  function automatic logic [W-1:0] bkAdd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic [W-1:0] p0;
    int dTop;
    g    = a & b;
    p    = a ^ b;
    p0   = p;
    dTop = 1;
    for (int d = 1; d < W; d = d * 2) begin
      dTop = d;
      for (int i = 2*d - 1; i < W; i = i + 2*d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    for (int d = dTop; d >= 1; d = d / 2) begin
      for (int i = 3*d - 1; i < W; i = i + 2*d) begin
        g[i] = g[i] | (p[i] & g[i-d]);
        p[i] = p[i] & p[i-d];
      end
    end
    return p0 ^ {g[W-2:0], 1'b0};
  endfunction

  logic         adv1;
  logic         adv2;

  logic         s1Valid_q, s1Valid_d;
  logic [W-1:0] s1Eab_q, s1Eab_d;
  logic [ex_width-1:0] s1Ec_q, s1Ec_d;
  logic         s1Mode_q, s1Mode_d;
  logic         s1Inf_q, s1Inf_d;
  logic         s1Zero_q, s1Zero_d;
  logic [TAG_W-1:0] s1Tag_q, s1Tag_d;

  logic         outValid_q, outValid_d;
  logic [W-1:0] shift_q, shift_d;
  logic [W-1:0] sd_q, sd_d;
  logic [W-1:0] maxExp_q, maxExp_d;
  logic         prodUndf_q, prodUndf_d;
  logic         shiftSat_q, shiftSat_d;
  logic         specInf_q, specInf_d;
  logic         specZero_q, specZero_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic [W-1:0] sumAb;
  logic [W-1:0] sdC;
  logic [W-1:0] tC;

  assign adv2     = !outValid_q || out_ready;
  assign adv1     = !s1Valid_q || adv2;
  assign in_ready = adv1;

  // Stage 1 next state: form Eab and special flags for an accepted input, else hold.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Eab_d   = s1Eab_q;
    s1Ec_d    = s1Ec_q;
    s1Mode_d  = s1Mode_q;
    s1Inf_d   = s1Inf_q;
    s1Zero_d  = s1Zero_q;
    s1Tag_d   = s1Tag_q;
    sumAb     = bkAdd({2'b00, Ea}, {2'b00, Eb});
    if (adv1) begin
      s1Valid_d = in_valid;
    end
    if (adv1 && in_valid) begin
      s1Eab_d  = mode ? {2'b00, Ea} : (sumAb - BIAS);
      s1Ec_d   = Ec;
      s1Mode_d = mode;
      s1Tag_d  = tag_in;
      s1Inf_d  = (Ea == EXP_ONES) || (Ec == EXP_ONES) || (!mode && (Eb == EXP_ONES));
      s1Zero_d = (Ea == EXP_ZERO) || (Ec == EXP_ZERO) || (!mode && (Eb == EXP_ZERO));
    end
  end

  // Stage 2 next state: difference, max, saturating shift; loads only when stage 1 moves down.
  always_comb begin
    outValid_d = outValid_q;
    shift_d    = shift_q;
    sd_d       = sd_q;
    maxExp_d   = maxExp_q;
    prodUndf_d = prodUndf_q;
    shiftSat_d = shiftSat_q;
    specInf_d  = specInf_q;
    specZero_d = specZero_q;
    tag_d      = tag_q;
    sdC        = s1Eab_q - {2'b00, s1Ec_q};
    tC         = sdC + SHIFT_OFF;
    if (adv2) begin
      outValid_d = s1Valid_q;
    end
    if (adv2 && s1Valid_q) begin
      sd_d       = sdC;
      maxExp_d   = sdC[W-1] ? {2'b00, s1Ec_q} : s1Eab_q;
      prodUndf_d = !s1Mode_q && s1Eab_q[W-1];
      specInf_d  = s1Inf_q;
      specZero_d = s1Zero_q;
      tag_d      = s1Tag_q;
      if (tC[W-1]) begin
        shift_d    = '0;
        shiftSat_d = 1'b0;
      end else if (tC > MAX_SHIFT_W) begin
        shift_d    = MAX_SHIFT_W;
        shiftSat_d = 1'b1;
      end else begin
        shift_d    = tC;
        shiftSat_d = 1'b0;
      end
    end
  end

  // Pipeline registers; reset empties both stages and clears all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Eab_q    <= '0;
      s1Ec_q     <= '0;
      s1Mode_q   <= 1'b0;
      s1Inf_q    <= 1'b0;
      s1Zero_q   <= 1'b0;
      s1Tag_q    <= '0;
      outValid_q <= 1'b0;
      shift_q    <= '0;
      sd_q       <= '0;
      maxExp_q   <= '0;
      prodUndf_q <= 1'b0;
      shiftSat_q <= 1'b0;
      specInf_q  <= 1'b0;
      specZero_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Eab_q    <= s1Eab_d;
      s1Ec_q     <= s1Ec_d;
      s1Mode_q   <= s1Mode_d;
      s1Inf_q    <= s1Inf_d;
      s1Zero_q   <= s1Zero_d;
      s1Tag_q    <= s1Tag_d;
      outValid_q <= outValid_d;
      shift_q    <= shift_d;
      sd_q       <= sd_d;
      maxExp_q   <= maxExp_d;
      prodUndf_q <= prodUndf_d;
      shiftSat_q <= shiftSat_d;
      specInf_q  <= specInf_d;
      specZero_q <= specZero_d;
      tag_q      <= tag_d;
    end
  end

  assign out_valid = outValid_q;
  assign shift     = shift_q;
  assign sd        = sd_q;
  assign max_exp   = maxExp_q;
  assign prod_undf = prodUndf_q;
  assign shift_sat = shiftSat_q;
  assign spec_inf  = specInf_q;
  assign spec_zero = specZero_q;
  assign tag_out   = tag_q;

endmodule

// File: tb/tb_exp_logic_pipe.sv
// Self-checking bench for exp_logic_pipe: directed vectors, streaming with
// random back-pressure, a full-pipe stall and reset in mid-stream.
module tb_exp_logic_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [7:0] Ea, Eb, Ec;
  logic [3:0] tag_in;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] shift, sd, max_exp;
  logic       prod_undf, shift_sat, spec_inf, spec_zero;
  logic [3:0] tag_out;
  logic [37:0] dutOut;

  int errors = 0;
  int checks = 0;
  logic [37:0] sb[$];

  exp_logic_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .Ea(Ea), .Eb(Eb), .Ec(Ec), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .shift(shift), .sd(sd), .max_exp(max_exp), .prod_undf(prod_undf),
    .shift_sat(shift_sat), .spec_inf(spec_inf), .spec_zero(spec_zero),
    .tag_out(tag_out)
  );

  assign dutOut = {shift, sd, max_exp, prod_undf, shift_sat, spec_inf, spec_zero, tag_out};

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model in plain integer arithmetic, packed like dutOut.
  function automatic logic [37:0] model(input logic m, input logic [7:0] ea,
                                        input logic [7:0] eb, input logic [7:0] ec,
                                        input logic [3:0] tg);
    int a, b, c, eab, sdv, t, sh;
    logic sat, undf, inf, zero;
    logic [9:0] mx;
    a = ea; b = eb; c = ec;
    eab  = m ? a : a + b - 127;
    sdv  = eab - c;
    mx   = (sdv < 0) ? 10'(c) : 10'(eab);
    t    = sdv + 27;
    sat  = 1'b0;
    if (t < 0) sh = 0;
    else if (t > 74) begin sh = 74; sat = 1'b1; end
    else sh = t;
    undf = !m && (eab < 0);
    inf  = (a == 255) || (c == 255) || (!m && b == 255);
    zero = (a == 0) || (c == 0) || (!m && b == 0);
    return {10'(sh), 10'(sdv), mx, undf, sat, inf, zero, tg};
  endfunction

  task automatic driveRandomOp();
    mode   = ($urandom_range(0, 3) == 0);
    Ea     = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    Eb     = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
    Ec     = 8'($urandom_range(0, 255));
    tag_in = 4'($urandom_range(0, 15));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    mode = 1'b0; Ea = '0; Eb = '0; Ec = '0; tag_in = '0;
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (dutOut !== 38'h0) begin
      errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", dutOut);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic       vm[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] va[5]  = '{8'd130, 8'd130, 8'd254, 8'd10, 8'd255};
    logic [7:0] vb[5]  = '{8'd127, 8'd127, 8'd254, 8'd10, 8'd0};
    logic [7:0] vc[5]  = '{8'd128, 8'd200, 8'd1, 8'd0, 8'd100};
    logic [9:0] vsd[5] = '{10'd2, 10'h3BA, 10'd380, 10'd917, 10'd155};
    logic [9:0] vsh[5] = '{10'd29, 10'd0, 10'd74, 10'd0, 10'd74};
    logic [37:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; mode = vm[k]; Ea = va[k]; Eb = vb[k]; Ec = vc[k]; tag_in = 4'(k + 5);
      sb.push_back(model(vm[k], va[k], vb[k], vc[k], 4'(k + 5)));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL dir%0d_in_ready: got %b expected 1", k, in_ready);
      end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL dir%0d_early_valid: got %b expected 0", k, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL dir%0d_latency: got %b expected 1", k, out_valid);
      end
      exp = sb.pop_front();
      checks++;
      if (dutOut !== exp) begin
        errors++; $display("[TB] FAIL dir%0d_result: got %h expected %h", k, dutOut, exp);
      end
      checks++;
      if ({sd, shift} !== {vsd[k], vsh[k]}) begin
        errors++; $display("[TB] FAIL dir%0d_sd_shift: got sd=%h shift=%0d expected sd=%h shift=%0d",
                           k, sd, shift, vsd[k], vsh[k]);
      end
    end
  endtask

  task automatic test_back_to_back(input int nOps, input int readyPct, input string name);
    int sent = 0, got = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [37:0] held, exp;
    while (got < nOps && cyc < 50 * nOps) begin
      @(posedge clk); #1;
      cyc++;
      in_valid  = (sent < nOps) && ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 99) < readyPct);
      driveRandomOp();
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || dutOut !== held) begin
          errors++; $display("[TB] FAIL %s_hold: got v=%b %h expected v=1 %h", name, out_valid, dutOut, held);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(mode, Ea, Eb, Ec, tag_in));
        sent++;
      end
      stalled = out_valid && !out_ready;
      held    = dutOut;
      if (out_valid && out_ready) begin
        got++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("[TB] FAIL %s_spurious: got %h expected no output", name, dutOut);
        end else begin
          exp = sb.pop_front();
          if (dutOut !== exp) begin
            errors++; $display("[TB] FAIL %s_result: got %h expected %h", name, dutOut, exp);
          end
        end
      end
    end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++;
    if (got != nOps) begin
      errors++; $display("[TB] FAIL %s_timeout: got %0d results expected %0d", name, got, nOps);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pa[4] = '{8'd130, 8'd20, 8'd254, 8'd100};
    logic [7:0] pc[4] = '{8'd128, 8'd250, 8'd3, 8'd0};
    logic [3:0] ptag[4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    int next = 0, got = 0;
    logic [37:0] first, exp;
    first = '0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      out_ready = (c >= 6);
      in_valid  = (next < 4);
      mode = 1'b0; Eb = 8'd127;
      Ea = pa[next % 4]; Ec = pc[next % 4]; tag_in = ptag[next % 4];
      @(negedge clk);
      if (c == 2) first = dutOut;
      if (c >= 3 && c <= 5) begin
        checks++;
        if (out_valid !== 1'b1 || dutOut !== first) begin
          errors++; $display("[TB] FAIL bp_stable: got v=%b %h expected v=1 %h", out_valid, dutOut, first);
        end
      end
      if (c == 5) begin
        checks++;
        if (next != 2 || in_ready !== 1'b0) begin
          errors++; $display("[TB] FAIL bp_in_ready: got accepts=%0d in_ready=%b expected 2 and 0", next, in_ready);
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(1'b0, pa[next], 8'd127, pc[next], ptag[next]));
        next++;
      end
      if (out_valid && out_ready) begin
        exp = sb.pop_front();
        checks++;
        if (dutOut !== exp || tag_out !== ptag[got]) begin
          errors++; $display("[TB] FAIL bp_order%0d: got %h tag=%0d expected %h tag=%0d",
                             got, dutOut, tag_out, exp, ptag[got]);
        end
        got++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin
      errors++; $display("[TB] FAIL bp_count: got %0d results expected 4", got);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; driveRandomOp();
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || dutOut !== 38'h0) begin
      errors++; $display("[TB] FAIL midrst_clear: got v=%b %h expected v=0 0", out_valid, dutOut);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL midrst_stale%0d: got %b expected 0", c, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(40, 100, "b2b");
    test_back_to_back(60, 50, "stall");
    test_backpressure();
    test_reset_midstream();
    test_back_to_back(20, 70, "post_reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exp_logic_pipe.md
Name: exp_logic_pipe

Overview:
- Pipelined, parametrised successor to the combinational FMA exponent logic.
- Computes product exponent, signed exponent difference, max exponent and alignment shift.
- Adds:
  - valid/ready handshake with back-pressure
  - a 2-stage register pipeline
  - FMA/ADD mode select
  - shift saturation
  - special-exponent flags and a passthrough tag
- Sits between operand unpack and the significand alignment shifter in the FP MAC datapath.

Parameters:
- sig_width, 23, significand fraction width.
- ex_width, 8, exponent width; bias = 2**(ex_width-1)-1.
- MAX_SHIFT, 3*sig_width+5, upper clamp for the alignment shift (74 at defaults).
- TAG_W, 4, width of the opaque tag carried alongside each operation.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input operation valid.
- in_ready, out, 1, block can accept input this cycle.
- mode, in, 1, 0 = FMA (a*b+c), 1 = ADD (a+c, Eb ignored).
- Ea, in, ex_width, biased exponent of A.
- Eb, in, ex_width, biased exponent of B.
- Ec, in, ex_width, biased exponent of C.
- tag_in, in, TAG_W, opaque tag.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts result.
- shift, out, ex_width+2, alignment shift for C, clamped to [0, MAX_SHIFT].
- sd, out, ex_width+2, signed Eab - Ec (two's complement).
- max_exp, out, ex_width+2, larger of Eab and Ec.
- prod_undf, out, 1, Eab negative (signed).
- shift_sat, out, 1, unclamped shift exceeded MAX_SHIFT.
- spec_inf, out, 1, any participating exponent is all-ones.
- spec_zero, out, 1, any participating exponent is zero.
- tag_out, out, TAG_W, tag of the result.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- On rst_n low:
  - stage valids s1_valid, s2_valid and out_valid are 0.
  - All data outputs and tag_out are 0.
  - in_ready is 1 once rst_n is high.
- Internal arithmetic width is W = ex_width+2.
  - Operands are zero-extended.
  - sd is interpreted as signed.
  - Overflow cannot occur for legal inputs.
- Stage 1 (registered):
  - FMA: Eab = Ea + Eb - bias, computed with a BKA adder for Ea+Eb followed by a bias subtract.
  - ADD: Eab = {2'b0, Ea}.
  - Stage 1 also registers Ec, mode, tag and the special flags.
  - Participating exponents: FMA uses Ea, Eb, Ec; ADD uses Ea, Ec.
- Stage 2 (registered, drives outputs):
  - prod_undf = Eab[W-1] (forced 0 in ADD mode).
  - sd = Eab - Ec.
  - max_exp = sd[W-1] ? {2'b0, Ec} : Eab.
  - Shift offset: t = sd + (sig_width+4).
  - If t[W-1] = 1: shift = 0, shift_sat = 0.
  - Else if t > MAX_SHIFT: shift = MAX_SHIFT, shift_sat = 1.
  - Else: shift = t, shift_sat = 0.
- Handshake:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1, combinational from out_ready and state.
  - Input is accepted when in_valid && in_ready.
  - Latency is 2 cycles from acceptance to out_valid with no stall.
  - Throughput is 1 operation/cycle.
- Stall rules:
  - While out_valid && !out_ready, all outputs hold stable.
  - Stage 1 holds if occupied.
  - in_ready drops only when both stages are full and stalled.
- Bubbles:
  - Invalid inputs do not disturb held results.
  - Data registers update only when their stage advances with valid data.
- Simultaneous events: a result leaving while a new input enters in the same cycle is legal and loses no data.
- Ordering: results emerge in acceptance order, with tags unchanged.
- Reset mid-operation: in-flight operations are discarded with no output.

Test Plan:
- FMA, Ea=130, Eb=127, Ec=128, tag=5, out_ready=1 → after 2 cycles:
  - sd=2, max_exp=130, shift=29, prod_undf=0, shift_sat=0, tag_out=5.
- FMA, Ea=130, Eb=127, Ec=200 → sd=-70 (0x3BA), max_exp=200, shift=0, shift_sat=0.
- FMA, Ea=254, Eb=254, Ec=1 → sd=380, max_exp=381, shift=74, shift_sat=1.
- FMA, Ea=10, Eb=10, Ec=0 → prod_undf=1 and spec_zero=1.
- ADD, Ea=255, Eb=0, Ec=100:
  - Eab=255, sd=155, shift=74, shift_sat=1.
  - spec_inf=1, spec_zero=0 (Eb ignored).
- Back-pressure and reset:
  - Stream 4 ops with out_ready held 0.
  - in_ready must fall after 2 accepts, and outputs stay stable.
  - Release out_ready: all 4 results emerge in order with correct tags.
  - Assert rst_n low mid-stream: out_valid goes 0 at once and no stale result appears afterwards.
